// File: rtl/mem_req_arbiter_pkg.sv
// Shared definitions for the memory request arbiter: FSM state encoding
// and the helper that sizes channel-index fields.
package mem_req_arbiter_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,  // no grant held, arbitration is free-running
    ST_LOCK = 1'b1   // a request was presented but not yet accepted
  } arb_state_t;

  // Width needed to hold a channel index for n channels (at least one bit).
  function automatic int ch_idx_w(input int n);
    if (n <= 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/mem_req_arbiter_tag_fifo.sv
// Small tag FIFO remembering which channel issued each outstanding request,
// so in-order responses can be routed back to their originator.
module tag_fifo #(
  parameter int W     = 1,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] cnt_r;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign full      = (cnt_r == CW'(DEPTH));
  assign empty     = (cnt_r == {CW{1'b0}});
  assign head      = mem_r[rd_ptr_r];
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;

  // Pointer and occupancy tracking; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      cnt_r    <= {CW{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   cnt_r <= cnt_r + CW'(1);
        2'b01:   cnt_r <= cnt_r - CW'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Tag storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter merging NUM_CH upstream memory request channels onto a
// single downstream port. A presented-but-unaccepted request is locked until
// accepted; responses are routed back in issue order through a tag FIFO.
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int OUTST_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH-1:0]          up_req,
  input  logic [NUM_CH-1:0]          up_wr,
  input  logic [NUM_CH*DATA_W/8-1:0] up_wstrb,
  input  logic [NUM_CH*ADDR_W-1:0]   up_addr,
  input  logic [NUM_CH*DATA_W-1:0]   up_wdata,
  output logic [NUM_CH-1:0]          up_addr_ok,
  output logic [NUM_CH-1:0]          up_data_ok,
  output logic [DATA_W-1:0]          up_rdata,
  output logic                       mem_req,
  output logic                       mem_wr,
  output logic [DATA_W/8-1:0]        mem_wstrb,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  input  logic                       mem_addr_ok,
  input  logic                       mem_data_ok,
  input  logic [DATA_W-1:0]          mem_rdata
);

  localparam int CH_W = ch_idx_w(NUM_CH);
  localparam int SW   = DATA_W / 8;

  arb_state_t      state_r;
  logic [CH_W-1:0] rr_ptr_r;
  logic [CH_W-1:0] lock_ch_r;
  logic [CH_W-1:0] pick_s;
  logic            pick_vld_s;
  logic [CH_W-1:0] grant_s;
  logic            req_vld_s;
  logic            hs_s;
  logic            pop_s;
  logic            full_s;
  logic            empty_s;
  logic [CH_W-1:0] head_s;
  int              idx_s;

  // Round-robin search starting at the pointer; lowest offset wins.
  always_comb begin
    pick_s     = {CH_W{1'b0}};
    pick_vld_s = 1'b0;
    idx_s      = 0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx_s = (int'(rr_ptr_r) + k) % NUM_CH;
      if (up_req[idx_s]) begin
        pick_s     = CH_W'(idx_s);
        pick_vld_s = 1'b1;
      end else begin
        pick_s     = pick_s;
        pick_vld_s = pick_vld_s;
      end
    end
  end

  // Locked grant overrides arbitration; full FIFO or reset masks the request.
  always_comb begin
    if (state_r == ST_LOCK) begin
      grant_s   = lock_ch_r;
      req_vld_s = 1'b1;
    end else begin
      grant_s   = pick_s;
      req_vld_s = pick_vld_s;
    end
    mem_req   = req_vld_s & ~full_s & ~rst;
    mem_wr    = up_wr[grant_s];
    mem_wstrb = up_wstrb[int'(grant_s) * SW +: SW];
    mem_addr  = up_addr[int'(grant_s) * ADDR_W +: ADDR_W];
    mem_wdata = up_wdata[int'(grant_s) * DATA_W +: DATA_W];
  end

  assign hs_s     = mem_req & mem_addr_ok;
  assign pop_s    = mem_data_ok & ~empty_s & ~rst;
  assign up_rdata = mem_rdata;

  // One-hot accept and response strobes for the granted / head-of-FIFO channel.
  always_comb begin
    up_addr_ok = {NUM_CH{1'b0}};
    up_data_ok = {NUM_CH{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      up_addr_ok[i] = hs_s && (grant_s == CH_W'(i));
      up_data_ok[i] = pop_s && (head_s == CH_W'(i));
    end
  end

  // Grant lock FSM and round-robin pointer, which moves only on acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      lock_ch_r <= {CH_W{1'b0}};
      rr_ptr_r  <= {CH_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (mem_req && !mem_addr_ok) begin
            state_r   <= ST_LOCK;
            lock_ch_r <= grant_s;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_LOCK: begin
          if (hs_s) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_LOCK;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
      if (hs_s) begin
        if (grant_s == CH_W'(NUM_CH - 1)) begin
          rr_ptr_r <= {CH_W{1'b0}};
        end else begin
          rr_ptr_r <= grant_s + CH_W'(1);
        end
      end
    end
  end

  tag_fifo #(
    .W     (CH_W),
    .DEPTH (OUTST_DEPTH)
  ) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (hs_s),
    .pop   (pop_s),
    .din   (grant_s),
    .full  (full_s),
    .empty (empty_s),
    .head  (head_s)
  );

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed testbench for mem_req_arbiter (4 channels, 4 outstanding tags).
module tb_mem_req_arbiter;

  localparam int NUM_CH      = 4;
  localparam int ADDR_W      = 32;
  localparam int DATA_W      = 32;
  localparam int OUTST_DEPTH = 4;
  localparam int SW          = DATA_W / 8;

  logic                     clk;
  logic                     rst;
  logic [NUM_CH-1:0]        up_req;
  logic [NUM_CH-1:0]        up_wr;
  logic [NUM_CH*SW-1:0]     up_wstrb;
  logic [NUM_CH*ADDR_W-1:0] up_addr;
  logic [NUM_CH*DATA_W-1:0] up_wdata;
  logic [NUM_CH-1:0]        up_addr_ok;
  logic [NUM_CH-1:0]        up_data_ok;
  logic [DATA_W-1:0]        up_rdata;
  logic                     mem_req;
  logic                     mem_wr;
  logic [SW-1:0]            mem_wstrb;
  logic [ADDR_W-1:0]        mem_addr;
  logic [DATA_W-1:0]        mem_wdata;
  logic                     mem_addr_ok;
  logic                     mem_data_ok;
  logic [DATA_W-1:0]        mem_rdata;

  int vectors    = 0;
  int miscompares = 0;

  mem_req_arbiter #(
    .NUM_CH      (NUM_CH),
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .OUTST_DEPTH (OUTST_DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .up_req      (up_req),
    .up_wr       (up_wr),
    .up_wstrb    (up_wstrb),
    .up_addr     (up_addr),
    .up_wdata    (up_wdata),
    .up_addr_ok  (up_addr_ok),
    .up_data_ok  (up_data_ok),
    .up_rdata    (up_rdata),
    .mem_req     (mem_req),
    .mem_wr      (mem_wr),
    .mem_wstrb   (mem_wstrb),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_addr_ok (mem_addr_ok),
    .mem_data_ok (mem_data_ok),
    .mem_rdata   (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    up_req      = '0;
    up_wr       = '0;
    up_wstrb    = '0;
    up_addr     = '0;
    up_wdata    = '0;
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    mem_rdata   = '0;
  endtask

  task automatic set_ch(input int ch, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic wr, input logic [3:0] strb);
    up_addr[ch*ADDR_W +: ADDR_W]  = addr;
    up_wdata[ch*DATA_W +: DATA_W] = wdata;
    up_wr[ch]                     = wr;
    up_wstrb[ch*SW +: SW]         = strb;
  endtask

  task automatic do_reset;
    clear_inputs();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst         = 1'b1;
    clear_inputs();
    up_req      = 4'b1111;
    mem_addr_ok = 1'b1;
    mem_data_ok = 1'b1;
    mem_rdata   = 32'h1234_5678;
    step();
    #2;
    vectors++;
    if (mem_req !== 1'b0) begin
      $display("FAIL reset_mem_req: got %b expected 0", mem_req); miscompares++;
    end
    vectors++;
    if (up_addr_ok !== 4'b0000) begin
      $display("FAIL reset_addr_ok: got %b expected 0000", up_addr_ok); miscompares++;
    end
    vectors++;
    if (up_data_ok !== 4'b0000) begin
      $display("FAIL reset_data_ok: got %b expected 0000", up_data_ok); miscompares++;
    end
    vectors++;
    if (up_rdata !== 32'h1234_5678) begin
      $display("FAIL reset_rdata: got %h expected 12345678", up_rdata); miscompares++;
    end
    step();
    rst = 1'b0;
    clear_inputs();
    #2;
    vectors++;
    if (mem_req !== 1'b0) begin
      $display("FAIL idle_mem_req: got %b expected 0", mem_req); miscompares++;
    end
    step();
  endtask

  task automatic test_rr_reads;
    logic [3:0]  exp_g [8];
    logic [31:0] exp_a;
    exp_g = '{4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0000, 4'b0000};
    do_reset();
    set_ch(0, 32'h0000_00A0, 32'h0, 1'b0, 4'b0000);
    set_ch(1, 32'h0000_00B0, 32'h0, 1'b0, 4'b0000);
    mem_addr_ok = 1'b1;
    for (int c = 0; c < 8; c++) begin
      up_req = (c < 6) ? 4'b0011 : 4'b0000;
      if (c >= 2) begin
        mem_data_ok = 1'b1;
        mem_rdata   = 32'hD000_0000 + 32'(c);
      end else begin
        mem_data_ok = 1'b0;
      end
      #2;
      vectors++;
      if (up_addr_ok !== exp_g[c]) begin
        $display("FAIL rr_grant[%0d]: got %b expected %b", c, up_addr_ok, exp_g[c]); miscompares++;
      end
      if (exp_g[c] != 4'b0000) begin
        exp_a = (exp_g[c] == 4'b0001) ? 32'h0000_00A0 : 32'h0000_00B0;
        vectors++;
        if (mem_addr !== exp_a) begin
          $display("FAIL rr_addr[%0d]: got %h expected %h", c, mem_addr, exp_a); miscompares++;
        end
      end
      if (c >= 2) begin
        vectors++;
        if (up_data_ok !== exp_g[c-2]) begin
          $display("FAIL rr_data_ok[%0d]: got %b expected %b", c, up_data_ok, exp_g[c-2]); miscompares++;
        end
        vectors++;
        if (up_rdata !== 32'hD000_0000 + 32'(c)) begin
          $display("FAIL rr_rdata[%0d]: got %h expected %h", c, up_rdata, 32'hD000_0000 + 32'(c)); miscompares++;
        end
      end else begin
        vectors++;
        if (up_data_ok !== 4'b0000) begin
          $display("FAIL rr_data_ok[%0d]: got %b expected 0000", c, up_data_ok); miscompares++;
        end
      end
      step();
    end
    clear_inputs();
  endtask

  task automatic test_lock;
    logic [3:0]  req_v [5];
    logic        aok_v [5];
    logic [3:0]  exp_ok [5];
    logic [31:0] exp_a [5];
    req_v  = '{4'b0010, 4'b0011, 4'b0011, 4'b0011, 4'b0001};
    aok_v  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_ok = '{4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0001};
    exp_a  = '{32'h300, 32'h300, 32'h300, 32'h300, 32'h200};
    do_reset();
    set_ch(0, 32'h0000_0200, 32'h0, 1'b0, 4'b0000);
    set_ch(1, 32'h0000_0300, 32'h0, 1'b0, 4'b0000);
    for (int c = 0; c < 5; c++) begin
      up_req      = req_v[c];
      mem_addr_ok = aok_v[c];
      #2;
      vectors++;
      if (mem_req !== 1'b1) begin
        $display("FAIL lock_mem_req[%0d]: got %b expected 1", c, mem_req); miscompares++;
      end
      vectors++;
      if (mem_addr !== exp_a[c]) begin
        $display("FAIL lock_addr[%0d]: got %h expected %h", c, mem_addr, exp_a[c]); miscompares++;
      end
      vectors++;
      if (up_addr_ok !== exp_ok[c]) begin
        $display("FAIL lock_addr_ok[%0d]: got %b expected %b", c, up_addr_ok, exp_ok[c]); miscompares++;
      end
      step();
    end
    up_req      = 4'b0000;
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1;
    #2;
    vectors++;
    if (up_data_ok !== 4'b0010) begin
      $display("FAIL lock_resp0: got %b expected 0010", up_data_ok); miscompares++;
    end
    step();
    #2;
    vectors++;
    if (up_data_ok !== 4'b0001) begin
      $display("FAIL lock_resp1: got %b expected 0001", up_data_ok); miscompares++;
    end
    step();
    clear_inputs();
  endtask

  task automatic test_full;
    do_reset();
    set_ch(0, 32'h0000_0400, 32'h0, 1'b0, 4'b0000);
    up_req      = 4'b0001;
    mem_addr_ok = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #2;
      vectors++;
      if (up_addr_ok !== 4'b0001) begin
        $display("FAIL full_fill[%0d]: got %b expected 0001", c, up_addr_ok); miscompares++;
      end
      step();
    end
    #2;
    vectors++;
    if (mem_req !== 1'b0) begin
      $display("FAIL full_stall_req: got %b expected 0", mem_req); miscompares++;
    end
    vectors++;
    if (up_addr_ok !== 4'b0000) begin
      $display("FAIL full_stall_ok: got %b expected 0000", up_addr_ok); miscompares++;
    end
    step();
    mem_data_ok = 1'b1;
    mem_rdata   = 32'h0BAD_CAFE;
    #2;
    vectors++;
    if (mem_req !== 1'b0) begin
      $display("FAIL full_pop_req: got %b expected 0", mem_req); miscompares++;
    end
    vectors++;
    if (up_addr_ok !== 4'b0000) begin
      $display("FAIL full_pop_ok: got %b expected 0000", up_addr_ok); miscompares++;
    end
    vectors++;
    if (up_data_ok !== 4'b0001) begin
      $display("FAIL full_pop_data: got %b expected 0001", up_data_ok); miscompares++;
    end
    step();
    mem_data_ok = 1'b0;
    #2;
    vectors++;
    if (mem_req !== 1'b1) begin
      $display("FAIL full_resume_req: got %b expected 1", mem_req); miscompares++;
    end
    vectors++;
    if (up_addr_ok !== 4'b0001) begin
      $display("FAIL full_resume_ok: got %b expected 0001", up_addr_ok); miscompares++;
    end
    step();
    clear_inputs();
  endtask

  task automatic test_write;
    do_reset();
    set_ch(0, 32'h0000_0100, 32'hCAFE_F00D, 1'b1, 4'b0011);
    set_ch(1, 32'h0000_0999, 32'h1111_1111, 1'b0, 4'b1111);
    up_req      = 4'b0001;
    mem_addr_ok = 1'b1;
    #2;
    vectors++;
    if (mem_wr !== 1'b1) begin
      $display("FAIL wr_mem_wr: got %b expected 1", mem_wr); miscompares++;
    end
    vectors++;
    if (mem_wstrb !== 4'b0011) begin
      $display("FAIL wr_wstrb: got %b expected 0011", mem_wstrb); miscompares++;
    end
    vectors++;
    if (mem_addr !== 32'h0000_0100) begin
      $display("FAIL wr_addr: got %h expected 00000100", mem_addr); miscompares++;
    end
    vectors++;
    if (mem_wdata !== 32'hCAFE_F00D) begin
      $display("FAIL wr_wdata: got %h expected cafef00d", mem_wdata); miscompares++;
    end
    vectors++;
    if (up_addr_ok !== 4'b0001) begin
      $display("FAIL wr_addr_ok: got %b expected 0001", up_addr_ok); miscompares++;
    end
    step();
    up_req = 4'b0000;
    #2;
    vectors++;
    if (mem_req !== 1'b0) begin
      $display("FAIL wr_idle_req: got %b expected 0", mem_req); miscompares++;
    end
    step();
    mem_data_ok = 1'b1;
    #2;
    vectors++;
    if (up_data_ok !== 4'b0001) begin
      $display("FAIL wr_data_ok: got %b expected 0001", up_data_ok); miscompares++;
    end
    step();
    clear_inputs();
  endtask

  task automatic test_reset_mid;
    do_reset();
    set_ch(0, 32'h0000_0500, 32'h0, 1'b0, 4'b0000);
    set_ch(1, 32'h0000_0600, 32'h0, 1'b0, 4'b0000);
    up_req      = 4'b0001;
    mem_addr_ok = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #2;
      vectors++;
      if (up_addr_ok !== 4'b0001) begin
        $display("FAIL mid_accept[%0d]: got %b expected 0001", c, up_addr_ok); miscompares++;
      end
      step();
    end
    up_req = 4'b0000;
    rst    = 1'b1;
    #2;
    vectors++;
    if (mem_req !== 1'b0) begin
      $display("FAIL mid_rst_req: got %b expected 0", mem_req); miscompares++;
    end
    step();
    rst         = 1'b0;
    mem_data_ok = 1'b1;
    mem_rdata   = 32'h0000_0007;
    #2;
    vectors++;
    if (up_data_ok !== 4'b0000) begin
      $display("FAIL mid_stray_data_ok: got %b expected 0000", up_data_ok); miscompares++;
    end
    step();
    mem_data_ok = 1'b0;
    up_req      = 4'b0011;
    #2;
    vectors++;
    if (up_addr_ok !== 4'b0001) begin
      $display("FAIL mid_next_grant: got %b expected 0001", up_addr_ok); miscompares++;
    end
    vectors++;
    if (mem_addr !== 32'h0000_0500) begin
      $display("FAIL mid_next_addr: got %h expected 00000500", mem_addr); miscompares++;
    end
    step();
    clear_inputs();
  endtask

  task automatic test_rr_4ch;
    logic [3:0]  exp_g [4];
    logic [31:0] exp_a;
    exp_g = '{4'b0100, 4'b1000, 4'b0100, 4'b1000};
    do_reset();
    set_ch(2, 32'h0000_2000, 32'h0, 1'b0, 4'b0000);
    set_ch(3, 32'h0000_3000, 32'h0, 1'b0, 4'b0000);
    up_req      = 4'b1100;
    mem_addr_ok = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #2;
      exp_a = (exp_g[c] == 4'b0100) ? 32'h0000_2000 : 32'h0000_3000;
      vectors++;
      if (up_addr_ok !== exp_g[c]) begin
        $display("FAIL rr4_grant[%0d]: got %b expected %b", c, up_addr_ok, exp_g[c]); miscompares++;
      end
      vectors++;
      if (mem_addr !== exp_a) begin
        $display("FAIL rr4_addr[%0d]: got %h expected %h", c, mem_addr, exp_a); miscompares++;
      end
      step();
    end
    clear_inputs();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_rr_reads();
    test_lock();
    test_full();
    test_write();
    test_reset_mid();
    test_rr_4ch();
    do_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
